// File: rtl/comparator_pkg.sv
// comparator_pkg: shared result encoding and FSM states for the comparator family
package comparator_pkg;
    localparam logic [2:0] CMP_LT   = 3'b100;
    localparam logic [2:0] CMP_EQ   = 3'b010;
    localparam logic [2:0] CMP_GT   = 3'b001;
    localparam logic [2:0] CMP_NONE = 3'b000;
    typedef enum logic {ST_IDLE, ST_SHIFT} state_t;
endpackage

// File: rtl/comparator_bit.sv
// comparator_bit: combinational single-bit magnitude compare cell
module comparator_bit (
    input  logic a,
    input  logic b,
    output logic lt,
    output logic eq,
    output logic gt
);
    assign lt = ~a & b;
    assign eq = ~(a ^ b);
    assign gt = a & ~b;
endmodule

// File: rtl/serial_comparator.sv
// serial_comparator: MSB-first bit-serial magnitude comparator with start/busy/done handshake
module serial_comparator
    import comparator_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             signed_mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [0:2]       y
);
    localparam int IW = $clog2(WIDTH);
    state_t           state, state_n;
    logic [WIDTH-1:0] a_r, a_n, b_r, b_n;
    logic             mode_r, mode_n, done_n;
    logic [IW-1:0]    idx, idx_n;
    logic [0:2]       y_n;
    logic             lt, eq, gt, lt_f;

    comparator_bit u_bit (.a(a_r[idx]), .b(b_r[idx]), .lt(lt), .eq(eq), .gt(gt));

    // A set sign bit marks the negative, hence smaller, operand.
    assign lt_f = (mode_r && idx == IW'(WIDTH - 1)) ? gt : lt;
    assign busy = (state == ST_SHIFT);

    always_comb begin
        state_n = state;
        a_n     = a_r;
        b_n     = b_r;
        mode_n  = mode_r;
        idx_n   = idx;
        y_n     = y;
        done_n  = 1'b0;
        if (state == ST_IDLE) begin
            if (start) begin
                a_n     = a;
                b_n     = b;
                mode_n  = signed_mode;
                idx_n   = IW'(WIDTH - 1);
                state_n = ST_SHIFT;
            end
        end else if (!eq || idx == '0) begin
            y_n     = !eq ? (lt_f ? CMP_LT : CMP_GT) : CMP_EQ;
            done_n  = 1'b1;
            state_n = ST_IDLE;
        end else begin
            idx_n = idx - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_IDLE;
            a_r    <= '0;
            b_r    <= '0;
            mode_r <= 1'b0;
            idx    <= '0;
            y      <= CMP_NONE;
            done   <= 1'b0;
        end else begin
            state  <= state_n;
            a_r    <= a_n;
            b_r    <= b_n;
            mode_r <= mode_n;
            idx    <= idx_n;
            y      <= y_n;
            done   <= done_n;
        end
    end
endmodule

// File: tb/tb_serial_comparator.sv
// tb_serial_comparator: scoreboard bench for serial_comparator at WIDTH=8
module tb_serial_comparator;
    localparam int W = 8;
    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic         signed_mode = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         busy, done;
    logic [0:2]   y;
    int           tests = 0;
    int           fails = 0;
    int           cyc = 0;
    logic [2:0]   exp_y[$];
    int           exp_c[$];

    serial_comparator #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .signed_mode(signed_mode),
        .a(a), .b(b), .busy(busy), .done(done), .y(y)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [2:0] gold_y(input logic [W-1:0] x, input logic [W-1:0] z, input logic m);
        if (m) return ($signed(x) < $signed(z)) ? 3'b100 : (x == z) ? 3'b010 : 3'b001;
        return (x < z) ? 3'b100 : (x == z) ? 3'b010 : 3'b001;
    endfunction

    function automatic int gold_j(input logic [W-1:0] x, input logic [W-1:0] z);
        logic [W-1:0] d;
        d = x ^ z;
        for (int i = W - 1; i >= 0; i--) if (d[i]) return W - i;
        return W;
    endfunction

    // Drives a request just after a negedge; the next posedge accepts it.
    task automatic do_start(input logic [W-1:0] x, input logic [W-1:0] z, input logic m);
        a = x;
        b = z;
        signed_mode = m;
        start = 1'b1;
        exp_y.push_back(gold_y(x, z, m));
        exp_c.push_back(cyc + 1 + gold_j(x, z));
        @(negedge clk);
        start = 1'b0;
        chk("busy_after_start", {31'b0, busy}, 32'd1);
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && exp_y.size() != 0; i++) @(negedge clk);
        chk("drain", exp_y.size(), 32'd0);
        @(negedge clk);
    endtask

    task automatic wait_done();
        for (int i = 0; i < 40 && !done; i++) @(negedge clk);
        chk("done_seen", {31'b0, done}, 32'd1);
    endtask

    always @(negedge clk) begin
        if (done) begin
            chk("busy_at_done", {31'b0, busy}, 32'd0);
            if (exp_y.size() == 0) chk("extra_done", {31'b0, done}, 32'd0);
            else begin
                chk("y", {29'b0, y}, {29'b0, exp_y.pop_front()});
                chk("latency", cyc, exp_c.pop_front());
            end
        end
    end

    initial begin
        logic [W-1:0] ra, rb;
        repeat (2) @(negedge clk);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_done", {31'b0, done}, 32'd0);
        chk("rst_y", {29'b0, y}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        do_start(8'h3C, 8'h3C, 1'b0);
        drain();
        do_start(8'h80, 8'h7F, 1'b0);
        drain();
        do_start(8'h80, 8'h7F, 1'b1);
        drain();
        do_start(8'h41, 8'h40, 1'b0);
        wait_done();
        do_start(8'h40, 8'h41, 1'b0);
        drain();
        do_start(8'h10, 8'h30, 1'b0);
        start = 1'b1;
        a = 8'hFF;
        b = 8'h00;
        @(negedge clk);
        start = 1'b0;
        a = 8'h55;
        b = 8'hAA;
        drain();
        chk("y_hold", {29'b0, y}, 32'b100);
        do_start(8'h01, 8'h01, 1'b0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        exp_y.delete();
        exp_c.delete();
        @(negedge clk);
        chk("midrst_busy", {31'b0, busy}, 32'd0);
        chk("midrst_done", {31'b0, done}, 32'd0);
        chk("midrst_y", {29'b0, y}, 32'd0);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        do_start(8'hFE, 8'hFF, 1'b1);
        drain();
        for (int n = 0; n < 1000; n++) begin
            ra = W'($urandom);
            rb = ($urandom_range(0, 1) == 1) ? W'($urandom) : ra ^ (W'(1) << $urandom_range(0, W - 1));
            if ($urandom_range(0, 7) == 0) rb = ra;
            do_start(ra, rb, 1'($urandom_range(0, 1)));
            drain();
        end
        chk("queue_empty", exp_y.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/serial_comparator.md
# serial_comparator

Multi-cycle magnitude comparator for two WIDTH-bit words. It compares the words one bit per clock, MSB first, and stops at the first differing bit. It reports less/equal/greater on a one-hot y[0:2] bus, using the same encoding as the codebase's single-bit comparators. Upstream control logic drives it through a start/busy/done handshake, so a narrow compare datapath can serve wide operands.

## Interface
- WIDTH, 8, operand width in bits; legal range 2..32
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- start  input  1  request pulse; sampled only while idle
- signed_mode  input  1  1 = two's-complement compare, 0 = unsigned; sampled with start
- a  input  WIDTH  operand A; sampled with start
- b  input  WIDTH  operand B; sampled with start
- busy  output  1  high while a compare is in progress
- done  output  1  one-cycle pulse when y carries a new result
- y  output  [0:2]  one-hot result: y[0]=A<B, y[1]=A==B, y[2]=A>B; 3'b000 = no result yet

## Operation
- FSM has two states: IDLE and SHIFT.
- **IDLE.** busy=0. If start=1 at a clock edge:
  - capture a, b and signed_mode into internal registers;
  - load the bit index counter with WIDTH-1;
  - go to SHIFT.
  - With start=0, stay in IDLE.
- **SHIFT.** busy=1. Each edge examines bit i (the index counter) of the captured A and B.
  - Bits equal, i>0: decrement i and stay in SHIFT.
  - Bits equal, i==0: y<=EQ, done<=1, go to IDLE.
  - Bits differ: the result is final; y<=LT or GT, done<=1, go to IDLE.
- **Direction when bits differ:**
  - At i==WIDTH-1 with the captured mode signed: the operand whose bit is 1 is the smaller one (it is negative).
  - In every other case: the operand whose bit is 1 is the larger one.
- **Ignored inputs.** start is ignored while busy=1. Operand or mode changes after capture have no effect.
- **Result hold.** y holds its last result until the next done. done is high for exactly one cycle per accepted start.
- **Back-to-back starts.** start may be asserted in the same cycle done is high; the state is IDLE then, so the request is accepted.
- **Reset.** rst=1 at any edge, including mid-compare, forces state=IDLE, busy=0, done=0, y=3'b000 and clears the counter. A compare in flight is dropped with no done pulse. rst has priority over start.

## Timing
- start is accepted at edge E0; busy rises after E0.
- Let the first differing bit be the j-th bit examined, j=1..WIDTH. The result is registered at edge E0+j: y is valid and done=1 during the cycle after E0+j, and busy=0 in that same cycle.
- Equal operands take WIDTH cycles; this is the worst-case latency.
- Best case is 1 cycle (MSBs differ).
- Minimum request spacing is j+1 cycles; a new start may coincide with the previous done.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Structure
- Shared package/header `comparator_pkg`:
  - encoding constants CMP_LT=3'b100, CMP_EQ=3'b010, CMP_GT=3'b001, CMP_NONE=3'b000 (y[0:2] order);
  - FSM state constants ST_IDLE, ST_SHIFT.
- Sub-module `comparator_bit`: combinational 1-bit cell producing lt, eq, gt. It is instantiated once on the selected bit pair.
  - The signed-MSB inversion is applied outside the cell, in serial_comparator.
- Bit index counter width: $clog2(WIDTH).

## Test plan
- After reset, with WIDTH=8: rst held 2 cycles -> busy=0, done=0, y=000. start with a=8'h3C, b=8'h3C, unsigned -> busy for 8 cycles, then done pulse with y=010.
- a=8'h80, b=8'h7F, unsigned -> done one cycle after busy rises, y=001. Same operands with signed_mode=1 -> y=100, same latency.
- a=8'h41, b=8'h40, unsigned -> first difference is at bit 0, so 8 cycles to done, y=001. Then a=8'h40, b=8'h41 with start asserted on that done cycle -> accepted, y=100 after 8 more cycles.
- a=8'h10, b=8'h30 started; start re-pulsed with a=8'hFF, b=8'h00 and a/b changed while busy -> both ignored; done after 3 cycles with y=100 (0x10<0x30); exactly one done pulse.
- Mid-compare reset: start a=8'h01, b=8'h01, assert rst on cycle 4 -> next cycle busy=0, y=000, no done pulse. A following start a=8'hFE, b=8'hFF, signed -> y=100 after 8 cycles.
- Randomized sweep of 1000 operand pairs with random mode against a golden model -> y matches, done latency equals the first-difference position, exactly one done per accepted start.
